tlb_unit: RTL and testbench
===========================

// Module: tlb_unit
// PURPOSE
//  Joint TLB for the OpenMIPS core. Sits downstream of the CP0 register file.
//  - Consumes CP0 Index/EntryHi/EntryLo0/EntryLo1 to execute TLBWI/TLBR/TLBP.
//  - Translates fetch (IF) and load/store (MEM) virtual addresses, one-cycle registered latency.
//  - Returns TLB exception codes in the CP0 excepttype encoding.
// PARAMETERS
//  ENTRIES  16  number of TLB entries, power of 2, max 64
//  IDX_W    4   log2(ENTRIES); width of stored index
// PORTS
//  clk            in   1   clock
//  rst            in   1   synchronous reset, active-high
//  tlbwi_i        in   1   write entry Index[IDX_W-1:0] from CP0 EntryHi/Lo0/Lo1
//  tlbr_i         in   1   read entry Index into tlbr_* outputs
//  tlbp_i         in   1   probe for EntryHi VPN2/ASID
//  index_i        in   32  CP0 Index
//  entry_hi_i     in   32  CP0 EntryHi: VPN2[31:13], ASID[7:0]
//  entry_lo0_i    in   32  CP0 EntryLo0: PFN[25:6], C[5:3], D[2], V[1], G[0]
//  entry_lo1_i    in   32  CP0 EntryLo1, same layout as EntryLo0
//  probe_we_o     out  1   pulse: probe_index_o valid, CP0 writes Index
//  probe_index_o  out  32  {miss, 25'b0, idx zero-extended to 6 bits}
//  tlbr_we_o      out  1   pulse: tlbr_* valid, CP0 writes EntryHi/Lo0/Lo1
//  tlbr_hi_o      out  32  {VPN2, 5'b0, ASID}
//  tlbr_lo0_o     out  32  {6'b0, PFN0, C0, D0, V0, G}
//  tlbr_lo1_o     out  32  {6'b0, PFN1, C1, D1, V1, G}
//  if_req_i       in   1   fetch translate request
//  if_vaddr_i     in   32  fetch virtual address
//  if_valid_o     out  1   fetch result valid, 1 cycle after request
//  if_paddr_o     out  32  fetch physical address
//  if_exc_o       out  1   fetch raised TLB exception
//  if_excepttype_o out 32  exception code; 0 when if_exc_o=0
//  mem_req_i      in   1   data translate request
//  mem_we_i       in   1   1 = store, 0 = load
//  mem_vaddr_i    in   32  data virtual address
//  mem_valid_o / mem_paddr_o / mem_exc_o / mem_excepttype_o   out  same as if_* for data
// BEHAVIOUR
//  - Reset: every entry cleared (V0=V1=0, all fields 0); all outputs 0.
//  - Entry fields: VPN2[18:0], ASID[7:0], G, PFN0/1[19:0], C0/1[2:0], D0/1, V0/1. 4KB pages; no PageMask.
//  - TLBWI: entry[index_i[IDX_W-1:0]] written at the clk edge; G = lo0[0] & lo1[0]. Upper index bits ignored.
//  - TLBR: registered. Next cycle tlbr_we_o=1 with the entry formatted per PORTS.
//  - TLBP: registered. Next cycle probe_we_o=1.
//    - Hit: probe_index_o = {1'b0, 25'b0, idx}.
//    - Miss: probe_index_o = 32'h8000_0000.
//  - Match rule: VPN2 == vaddr[31:13] and (G or ASID == entry_hi_i[7:0]). Multiple matches: lowest index wins.
//  - Translation, registered, 1-cycle latency; *_valid_o = registered *_req_i.
//    - vaddr[31:30]==2'b10 (kseg0/kseg1): unmapped, paddr = {3'b000, vaddr[28:0]}, no exception.
//    - Otherwise mapped: vaddr[12] selects odd/even half; paddr = {PFN, vaddr[11:0]}.
//  - Exception codes:
//    - Miss or V=0: excepttype 2 (TLBL) for fetch/load, 3 (TLBS) for store.
//    - Store hit with V=1, D=0: excepttype 1 (Mod).
//    - On exception, paddr_o = 0.
//  - Lookups and TLBP in the same cycle as TLBWI see the pre-write contents (read-before-write).
//  - Simultaneous IF, MEM and probe requests are all served in parallel; no arbitration, no stall.
//  - tlbr_i and tlbp_i are never asserted together (one instruction); if they are, both are served.
//  - Reset mid-operation: pending registered results are dropped; valid/we outputs 0 the next cycle.
// CONFIGURATION
//  - TLB_ASID_EN defined: ASID compare as above.
//  - TLB_ASID_EN undefined: ASID ignored; every entry is treated as global.
//    ASID is still stored and returned by TLBR.
// STRUCTURE
//  - defines.v gains:
//    - `TLB_EXC_MOD 32'h1, `TLB_EXC_TLBL 32'h2, `TLB_EXC_TLBS 32'h3
//    - `TlbEntries 16, `TlbIdxBus 3:0
//    - field position macros for EntryHi/EntryLo
//  - Sub-module tlb_match: combinational compare of one {VPN2, ASID} against all entries.
//    Outputs hit and idx. Instantiated three times: IF, MEM, probe.
// TESTING
//  - Reset, then load 0x0040_0000 -> next cycle mem_exc_o=1, excepttype 2, paddr 0.
//  - TLBWI idx3: hi=0x0040_0005, lo0=0x0000_0046 (PFN 1, D, V); IF 0x0040_0010 with ASID 5
//    -> paddr 0x0000_1010, no exception.
//  - Same entry, lo0 D=0; store 0x0040_0010 -> excepttype 1. Load to the odd page (lo1 V=0) -> excepttype 2.
//  - TLBP hi=0x0040_0005 -> probe_index_o 0x0000_0003. TLBP hi=0x0080_0005 -> 0x8000_0000.
//  - TLBR idx3 -> tlbr_hi_o 0x0040_0005, tlbr_lo0_o 0x0000_0046.
//    Fetch 0xBFC0_0000 -> paddr 0x1FC0_0000, no exception.
//  - TLBWI and lookup of the same VPN in one cycle -> lookup returns the old (miss) result; the next lookup hits.
//    Mismatched ASID with G=0 -> miss with TLB_ASID_EN defined, hit without it.

Source files
------------

// File: rtl/tlb_pkg.sv
// Shared TLB types, CP0 field positions, exception codes and helpers.
// Optional feature: define TLB_ASID_EN to enable ASID comparison in lookups.
package tlb_pkg;

  localparam int TLB_ENTRIES = 16;
  localparam int TLB_IDX_W   = 4;

  // CP0 excepttype encodings for TLB faults
  localparam logic [31:0] TLB_EXC_MOD  = 32'h1;
  localparam logic [31:0] TLB_EXC_TLBL = 32'h2;
  localparam logic [31:0] TLB_EXC_TLBS = 32'h3;

  // EntryHi / EntryLo field positions
  localparam int HI_VPN2_LSB = 13;
  localparam int LO_PFN_MSB  = 25;
  localparam int LO_PFN_LSB  = 6;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  typedef struct packed {
    logic [31:0] paddr;
    logic        exc;
    logic [31:0] excepttype;
  } xlate_t;

  // Pack the CP0 EntryHi/Lo0/Lo1 registers into one stored entry
  function automatic tlb_entry_t make_entry(logic [31:0] hi, logic [31:0] lo0,
                                            logic [31:0] lo1);
    tlb_entry_t e;
    e.vpn2 = hi[31:HI_VPN2_LSB];
    e.asid = hi[7:0];
    e.g    = lo0[0] & lo1[0];
    e.pfn0 = lo0[LO_PFN_MSB:LO_PFN_LSB];
    e.c0   = lo0[5:3];
    e.d0   = lo0[2];
    e.v0   = lo0[1];
    e.pfn1 = lo1[LO_PFN_MSB:LO_PFN_LSB];
    e.c1   = lo1[5:3];
    e.d1   = lo1[2];
    e.v1   = lo1[1];
    return e;
  endfunction

  // Resolve one lookup: kseg0/kseg1 bypass, else page-half select and fault checks
  function automatic xlate_t translate(logic [31:0] vaddr, logic store, logic hit,
                                       tlb_entry_t e);
    xlate_t      r;
    logic [19:0] pfn;
    logic        v;
    logic        d;
    r   = '0;
    pfn = vaddr[12] ? e.pfn1 : e.pfn0;
    v   = vaddr[12] ? e.v1 : e.v0;
    d   = vaddr[12] ? e.d1 : e.d0;
    if (vaddr[31:30] == 2'b10) begin
      r.paddr = {3'b000, vaddr[28:0]};
    end else if (!hit || !v) begin
      r.exc        = 1'b1;
      r.excepttype = store ? TLB_EXC_TLBS : TLB_EXC_TLBL;
    end else if (store && !d) begin
      r.exc        = 1'b1;
      r.excepttype = TLB_EXC_MOD;
    end else begin
      r.paddr = {pfn, vaddr[11:0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/tlb_unit_match.sv
// Combinational compare of one {VPN2, ASID} against every TLB entry.
// ASID participates only when TLB_ASID_EN is defined; otherwise all entries are global.
module tlb_match
  import tlb_pkg::*;
#(
  parameter int ENTRIES = TLB_ENTRIES,
  parameter int IDX_W   = TLB_IDX_W
) (
  input  tlb_entry_t [ENTRIES-1:0] entries,
  input  logic [18:0]              vpn2,
  input  logic [7:0]               asid,
  output logic                     hit,
  output logic [IDX_W-1:0]         idx
);

`ifdef TLB_ASID_EN
  localparam bit ASID_EN = 1'b1;
`else
  localparam bit ASID_EN = 1'b0;
`endif

  // Priority search, scanning downward so the lowest matching index is kept last
  always_comb begin
    // NOTE: defaults first so every path assigns hit/idx and no latch is inferred.
    hit = 1'b0;
    idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (entries[i].vpn2 == vpn2 &&
          (entries[i].g || !ASID_EN || entries[i].asid == asid)) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/tlb_unit.sv
// Joint TLB: TLBWI/TLBR/TLBP plus parallel IF and MEM translation, 1-cycle latency.
// Optional feature: define TLB_ASID_EN to enable ASID comparison in lookups.
module tlb_unit
  import tlb_pkg::*;
#(
  parameter int ENTRIES = TLB_ENTRIES,
  parameter int IDX_W   = TLB_IDX_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tlbwi_i,
  input  logic        tlbr_i,
  input  logic        tlbp_i,
  input  logic [31:0] index_i,
  input  logic [31:0] entry_hi_i,
  input  logic [31:0] entry_lo0_i,
  input  logic [31:0] entry_lo1_i,
  output logic        probe_we_o,
  output logic [31:0] probe_index_o,
  output logic        tlbr_we_o,
  output logic [31:0] tlbr_hi_o,
  output logic [31:0] tlbr_lo0_o,
  output logic [31:0] tlbr_lo1_o,
  input  logic        if_req_i,
  input  logic [31:0] if_vaddr_i,
  output logic        if_valid_o,
  output logic [31:0] if_paddr_o,
  output logic        if_exc_o,
  output logic [31:0] if_excepttype_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_vaddr_i,
  output logic        mem_valid_o,
  output logic [31:0] mem_paddr_o,
  output logic        mem_exc_o,
  output logic [31:0] mem_excepttype_o
);

  tlb_entry_t [ENTRIES-1:0] entries;
  logic [IDX_W-1:0]         wr_idx;
  logic                     if_hit, mem_hit, p_hit;
  logic [IDX_W-1:0]         if_idx, mem_idx, p_idx;
  xlate_t                   if_x, mem_x;
  tlb_entry_t               rd_e;
  logic                     unused_bits;

  assign wr_idx      = index_i[IDX_W-1:0];
  assign rd_e        = entries[wr_idx];
  assign unused_bits = ^{index_i[31:IDX_W], entry_hi_i[12:8],
                         entry_lo0_i[31:26], entry_lo1_i[31:26]};

  tlb_match #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_if_match (
    .entries(entries), .vpn2(if_vaddr_i[31:13]), .asid(entry_hi_i[7:0]),
    .hit(if_hit), .idx(if_idx)
  );

  tlb_match #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_mem_match (
    .entries(entries), .vpn2(mem_vaddr_i[31:13]), .asid(entry_hi_i[7:0]),
    .hit(mem_hit), .idx(mem_idx)
  );

  tlb_match #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_probe_match (
    .entries(entries), .vpn2(entry_hi_i[31:13]), .asid(entry_hi_i[7:0]),
    .hit(p_hit), .idx(p_idx)
  );

  assign if_x  = translate(if_vaddr_i, 1'b0, if_hit, entries[if_idx]);
  assign mem_x = translate(mem_vaddr_i, mem_we_i, mem_hit, entries[mem_idx]);

  // Entry storage; lookups this cycle see the contents before the write lands
  always_ff @(posedge clk) begin
    // NOTE: the array is reset on purpose so every V bit starts cleared and no stale entry can hit.
    if (rst) begin
      entries <= '0;
    end else if (tlbwi_i) begin
      entries[wr_idx] <= make_entry(entry_hi_i, entry_lo0_i, entry_lo1_i);
    end
  end

  // Registered TLBR / TLBP results for CP0 write-back
  always_ff @(posedge clk) begin
    if (rst) begin
      probe_we_o    <= 1'b0;
      probe_index_o <= '0;
      tlbr_we_o     <= 1'b0;
      tlbr_hi_o     <= '0;
      tlbr_lo0_o    <= '0;
      tlbr_lo1_o    <= '0;
    end else begin
      probe_we_o <= tlbp_i;
      tlbr_we_o  <= tlbr_i;
      if (tlbp_i) probe_index_o <= p_hit ? 32'(p_idx) : 32'h8000_0000;
      if (tlbr_i) begin
        tlbr_hi_o  <= {rd_e.vpn2, 5'b0, rd_e.asid};
        tlbr_lo0_o <= {6'b0, rd_e.pfn0, rd_e.c0, rd_e.d0, rd_e.v0, rd_e.g};
        tlbr_lo1_o <= {6'b0, rd_e.pfn1, rd_e.c1, rd_e.d1, rd_e.v1, rd_e.g};
      end
    end
  end

  // Registered IF and MEM translation results
  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid_o       <= 1'b0;
      if_paddr_o       <= '0;
      if_exc_o         <= 1'b0;
      if_excepttype_o  <= '0;
      mem_valid_o      <= 1'b0;
      mem_paddr_o      <= '0;
      mem_exc_o        <= 1'b0;
      mem_excepttype_o <= '0;
    end else begin
      if_valid_o  <= if_req_i;
      mem_valid_o <= mem_req_i;
      if (if_req_i) begin
        if_paddr_o      <= if_x.paddr;
        if_exc_o        <= if_x.exc;
        if_excepttype_o <= if_x.excepttype;
      end
      if (mem_req_i) begin
        mem_paddr_o      <= mem_x.paddr;
        mem_exc_o        <= mem_x.exc;
        mem_excepttype_o <= mem_x.excepttype;
      end
    end
  end

endmodule

// File: tb/tb_tlb_unit.sv
// Scoreboard bench for tlb_unit: stimulus pushes expected responses, a monitor
// pops and compares whenever a valid/we output is seen.
module tb_tlb_unit;

  typedef struct {
    logic [31:0] paddr;
    logic        exc;
    logic [31:0] etype;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        tlbwi, tlbr, tlbp;
  logic [31:0] index, entry_hi, entry_lo0, entry_lo1;
  logic        probe_we;
  logic [31:0] probe_index;
  logic        tlbr_we;
  logic [31:0] tlbr_hi, tlbr_lo0, tlbr_lo1;
  logic        if_req;
  logic [31:0] if_vaddr;
  logic        if_valid;
  logic [31:0] if_paddr;
  logic        if_exc;
  logic [31:0] if_etype;
  logic        mem_req, mem_we;
  logic [31:0] mem_vaddr;
  logic        mem_valid;
  logic [31:0] mem_paddr;
  logic        mem_exc;
  logic [31:0] mem_etype;

  int tests  = 0;
  int failed = 0;

  exp_t        if_q[$];
  exp_t        mem_q[$];
  logic [31:0] probe_q[$];
  logic [95:0] tlbr_q[$];

  always #5 clk = ~clk;

  tlb_unit dut (
    .clk(clk), .rst(rst),
    .tlbwi_i(tlbwi), .tlbr_i(tlbr), .tlbp_i(tlbp),
    .index_i(index), .entry_hi_i(entry_hi),
    .entry_lo0_i(entry_lo0), .entry_lo1_i(entry_lo1),
    .probe_we_o(probe_we), .probe_index_o(probe_index),
    .tlbr_we_o(tlbr_we), .tlbr_hi_o(tlbr_hi),
    .tlbr_lo0_o(tlbr_lo0), .tlbr_lo1_o(tlbr_lo1),
    .if_req_i(if_req), .if_vaddr_i(if_vaddr),
    .if_valid_o(if_valid), .if_paddr_o(if_paddr),
    .if_exc_o(if_exc), .if_excepttype_o(if_etype),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_vaddr_i(mem_vaddr),
    .mem_valid_o(mem_valid), .mem_paddr_o(mem_paddr),
    .mem_exc_o(mem_exc), .mem_excepttype_o(mem_etype)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    tests++;
    failed++;
    $display("FAIL %s: output seen with no expected entry queued", name);
  endtask

  // Monitor: compare every presented result against the head of its queue
  always @(negedge clk) begin
    exp_t        e;
    logic [95:0] r;
    if (if_valid === 1'b1) begin
      if (if_q.size() == 0) unexpected("if_unexpected");
      else begin
        e = if_q.pop_front();
        check("if_paddr", if_paddr, e.paddr);
        check("if_exc", 32'(if_exc), 32'(e.exc));
        check("if_etype", if_etype, e.etype);
      end
    end
    if (mem_valid === 1'b1) begin
      if (mem_q.size() == 0) unexpected("mem_unexpected");
      else begin
        e = mem_q.pop_front();
        check("mem_paddr", mem_paddr, e.paddr);
        check("mem_exc", 32'(mem_exc), 32'(e.exc));
        check("mem_etype", mem_etype, e.etype);
      end
    end
    if (probe_we === 1'b1) begin
      if (probe_q.size() == 0) unexpected("probe_unexpected");
      else check("probe_index", probe_index, probe_q.pop_front());
    end
    if (tlbr_we === 1'b1) begin
      if (tlbr_q.size() == 0) unexpected("tlbr_unexpected");
      else begin
        r = tlbr_q.pop_front();
        check("tlbr_hi", tlbr_hi, r[95:64]);
        check("tlbr_lo0", tlbr_lo0, r[63:32]);
        check("tlbr_lo1", tlbr_lo1, r[31:0]);
      end
    end
  end

  // Advance one clock and drop every single-cycle request
  task automatic step();
    @(posedge clk);
    #1;
    tlbwi = 1'b0; tlbr = 1'b0; tlbp = 1'b0;
    if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
  endtask

  task automatic do_if(input logic [31:0] va, input logic [31:0] pa, input logic exc,
                       input logic [31:0] et);
    exp_t e;
    e.paddr = pa; e.exc = exc; e.etype = et;
    if_req = 1'b1; if_vaddr = va;
    if_q.push_back(e);
  endtask

  task automatic do_mem(input logic [31:0] va, input logic we, input logic [31:0] pa,
                        input logic exc, input logic [31:0] et);
    exp_t e;
    e.paddr = pa; e.exc = exc; e.etype = et;
    mem_req = 1'b1; mem_we = we; mem_vaddr = va;
    mem_q.push_back(e);
  endtask

  task automatic do_probe(input logic [31:0] hi, input logic [31:0] exp_idx);
    tlbp = 1'b1; entry_hi = hi;
    probe_q.push_back(exp_idx);
  endtask

  task automatic do_tlbr(input logic [31:0] idx, input logic [31:0] hi,
                         input logic [31:0] lo0, input logic [31:0] lo1);
    tlbr = 1'b1; index = idx;
    tlbr_q.push_back({hi, lo0, lo1});
  endtask

  task automatic do_tlbwi(input logic [31:0] idx, input logic [31:0] hi,
                          input logic [31:0] lo0, input logic [31:0] lo1);
    tlbwi = 1'b1; index = idx; entry_hi = hi; entry_lo0 = lo0; entry_lo1 = lo1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    tlbwi = 1'b0; tlbr = 1'b0; tlbp = 1'b0;
    index = '0; entry_hi = '0; entry_lo0 = '0; entry_lo1 = '0;
    if_req = 1'b0; if_vaddr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_vaddr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_if_valid", 32'(if_valid), 32'h0);
    check("reset_mem_valid", 32'(mem_valid), 32'h0);
    check("reset_probe_we", 32'(probe_we), 32'h0);
    check("reset_tlbr_we", 32'(tlbr_we), 32'h0);
    check("reset_if_paddr", if_paddr, 32'h0);
    check("reset_probe_index", probe_index, 32'h0);
    rst = 1'b0;

    // Empty TLB: load miss
    entry_hi = 32'h0040_0005;
    do_mem(32'h0040_0000, 1'b0, 32'h0, 1'b1, 32'h2);
    step();

    // Write idx3 while fetching the same page: fetch sees the old (miss) contents
    do_tlbwi(32'd3, 32'h0040_0005, 32'h0000_0046, 32'h0000_0000);
    do_if(32'h0040_0010, 32'h0, 1'b1, 32'h2);
    step();

    // Parallel fetch, store and probe, all hitting idx3
    do_if(32'h0040_0010, 32'h0000_1010, 1'b0, 32'h0);
    do_mem(32'h0040_0010, 1'b1, 32'h0000_1010, 1'b0, 32'h0);
    do_probe(32'h0040_0005, 32'h0000_0003);
    step();

    // Read back idx3; load to the invalid odd page
    do_tlbr(32'd3, 32'h0040_0005, 32'h0000_0046, 32'h0000_0000);
    do_mem(32'h0040_1010, 1'b0, 32'h0, 1'b1, 32'h2);
    step();
    do_mem(32'h0040_1010, 1'b1, 32'h0, 1'b1, 32'h3);
    step();

    // Clear D on the even page: store faults with Mod, load still translates
    do_tlbwi(32'd3, 32'h0040_0005, 32'h0000_0042, 32'h0000_0000);
    step();
    do_mem(32'h0040_0010, 1'b1, 32'h0, 1'b1, 32'h1);
    step();
    do_mem(32'h0040_0010, 1'b0, 32'h0000_1010, 1'b0, 32'h0);
    step();

    // Probe miss, kseg1 fetch and kseg0 load in one cycle
    do_probe(32'h0080_0005, 32'h8000_0000);
    do_if(32'hBFC0_0000, 32'h1FC0_0000, 1'b0, 32'h0);
    do_mem(32'h8000_1234, 1'b1, 32'h0000_1234, 1'b0, 32'h0);
    step();

    // Non-global entry looked up with a different ASID
    entry_hi = 32'h0040_0007;
`ifdef TLB_ASID_EN
    do_if(32'h0040_0010, 32'h0, 1'b1, 32'h2);
`else
    do_if(32'h0040_0010, 32'h0000_1010, 1'b0, 32'h0);
`endif
    step();

    // Global entry at idx1 (upper index bits ignored) overlapping idx3: lowest index wins
    do_tlbwi(32'h8000_0011, 32'h0040_0009, 32'h0000_0087, 32'h0000_00C7);
    step();
    entry_hi = 32'h0040_0005;
    do_if(32'h0040_0010, 32'h0000_2010, 1'b0, 32'h0);
    do_probe(32'h0040_0005, 32'h0000_0001);
    do_mem(32'h0040_1ABC, 1'b1, 32'h0000_3ABC, 1'b0, 32'h0);
    step();
    do_tlbr(32'h0000_0011, 32'h0040_0009, 32'h0000_0087, 32'h0000_00C7);
    step();
    step();

    // Reset with a request pending: no result may appear, entries are cleared
    if_req = 1'b1; if_vaddr = 32'h0040_0010; rst = 1'b1;
    step();
    check("rst_drop_if_valid", 32'(if_valid), 32'h0);
    rst = 1'b0;
    do_probe(32'h0040_0005, 32'h8000_0000);
    step();
    step();
    step();

    check("if_q_drained", 32'(if_q.size()), 32'h0);
    check("mem_q_drained", 32'(mem_q.size()), 32'h0);
    check("probe_q_drained", 32'(probe_q.size()), 32'h0);
    check("tlbr_q_drained", 32'(tlbr_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
